// File: rtl/x25519_ise_pkg.sv
// Shared types and elaboration helpers for the X25519 maddlu/maddhu multiply-accumulate unit.
package x25519_ise_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_LO  = 2'd0,
        OP_HI  = 2'd1,
        OP_ILL = 2'd2
    } op_e;

    localparam int XLEN_DEF      = 64;
    localparam int LIMB_BITS_DEF = 64;
    localparam int MUL_W_DEF     = 16;
    localparam int NIT_DEF       = XLEN_DEF / MUL_W_DEF;

    // Exactly one op bit selects a product half; anything else is rejected as illegal.
    function automatic op_e decode_op(input logic maddlu, input logic maddhu);
        op_e op;
        case ({maddhu, maddlu})
            2'b01:   op = OP_LO;
            2'b10:   op = OP_HI;
            default: op = OP_ILL;
        endcase
        return op;
    endfunction

    // Number of multiplier chunks consumed per operation.
    function automatic int nit_of(input int xlen, input int mul_w);
        return (mul_w > 0) ? (xlen / mul_w) : 1;
    endfunction

    // The counter also has to represent NIT itself, which marks the result-forming cycle.
    function automatic int cnt_width(input int nit);
        return (nit < 1) ? 1 : $clog2(nit + 1);
    endfunction

    function automatic bit params_legal(input int xlen, input int limb_bits, input int mul_w);
        return ((xlen == 32) || (xlen == 64)) &&
               (limb_bits >= 1) && (limb_bits <= xlen) &&
               (mul_w >= 1) && (mul_w <= xlen) && ((xlen % mul_w) == 0);
    endfunction

endpackage

// File: rtl/x25519_mul_step.sv
// One iteration of the shift-and-add multiplier: rs1 times a MUL_W-bit slice of rs2,
// aligned to the slice position and added into the double-width accumulator.
module x25519_mul_step
    import x25519_ise_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int MUL_W = MUL_W_DEF,
    parameter int CNT_W = 3
) (
    input  logic [2*XLEN-1:0]   acc_in,
    input  logic [XLEN-1:0]     multiplicand,
    input  logic [MUL_W-1:0]    chunk,
    input  logic [CNT_W-1:0]    step,
    output logic [2*XLEN-1:0]   acc_out
);

    logic [XLEN+MUL_W-1:0] partial;
    logic [2*XLEN-1:0]     partial_ext;
    logic [31:0]           shamt;

    // Form the partial product, place it at the slice's bit offset and accumulate.
    always_comb begin
        partial     = (XLEN+MUL_W)'(multiplicand) * (XLEN+MUL_W)'(chunk);
        partial_ext = (2*XLEN)'(partial);
        shamt       = 32'(step) * 32'(MUL_W);
        acc_out     = acc_in + (partial_ext << shamt);
    end

endmodule

// File: rtl/x25519_ise_mac.sv
// Iterative multiply-accumulate unit behind maddlu/maddhu: rd = lo/hi(rs1*rs2) + rs3,
// with valid/ready handshakes towards issue and writeback.
module x25519_ise_mac
    import x25519_ise_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int LIMB_BITS = LIMB_BITS_DEF,
    parameter int MUL_W     = MUL_W_DEF
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] rs3,
    input  logic            op_maddlu,
    input  logic            op_maddhu,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd
);

    localparam int NIT   = nit_of(XLEN, MUL_W);
    localparam int CNT_W = cnt_width(NIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIT);
    localparam logic [XLEN-1:0]  LO_MASK  = {XLEN{1'b1}} >> (XLEN - LIMB_BITS);

    if (!params_legal(XLEN, LIMB_BITS, MUL_W)) begin : g_bad_params
        $fatal(1, "x25519_ise_mac: illegal XLEN/LIMB_BITS/MUL_W combination");
    end

    state_e             state;
    op_e                op_q;
    op_e                op_in;
    logic [XLEN-1:0]    rs1_q;
    logic [XLEN-1:0]    rs2_q;
    logic [XLEN-1:0]    rs3_q;
    logic [2*XLEN-1:0]  acc;
    logic [2*XLEN-1:0]  acc_next;
    logic [CNT_W-1:0]   cnt;
    logic [XLEN-1:0]    lo_part;
    logic [XLEN-1:0]    hi_part;
    logic [XLEN-1:0]    result;

    assign op_in = decode_op(op_maddlu, op_maddhu);

    // rs2_q is shifted down each iteration, so its low slice is always the current chunk.
    x25519_mul_step #(
        .XLEN  (XLEN),
        .MUL_W (MUL_W),
        .CNT_W (CNT_W)
    ) u_mul_step (
        .acc_in       (acc),
        .multiplicand (rs1_q),
        .chunk        (rs2_q[MUL_W-1:0]),
        .step         (cnt),
        .acc_out      (acc_next)
    );

    // Pick the requested product half and add the addend; carry-out falls off the top.
    always_comb begin
        lo_part = acc[XLEN-1:0] & LO_MASK;
        hi_part = XLEN'(acc >> LIMB_BITS);
        result  = '0;
        case (op_q)
            OP_LO:   result = lo_part + rs3_q;
            OP_HI:   result = hi_part + rs3_q;
            default: result = '0;
        endcase
    end

    // Control FSM; the extra cycle after the last chunk registers rd so the rs3 adder
    // stays off the accumulator path.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state     <= IDLE;
            op_q      <= OP_ILL;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rs3_q     <= '0;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rd        <= '0;
        end else if (flush) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rd        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rs1_q    <= rs1;
                        rs2_q    <= rs2;
                        rs3_q    <= rs3;
                        op_q     <= op_in;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        if (op_in == OP_ILL) begin
                            state     <= DONE;
                            rd        <= '0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (cnt == LAST_CNT) begin
                        rd        <= result;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc   <= acc_next;
                        rs2_q <= rs2_q >> MUL_W;
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x25519_ise_mac.sv
// Self-checking bench: a full-radix and a 51-bit-limb instance share one stimulus bus and
// are compared against a plain-arithmetic reference model.
module tb_x25519_ise_mac;

    localparam int XLEN  = 64;
    localparam int MUL_W = 16;
    localparam int NIT   = XLEN / MUL_W;
    localparam int BOUND = 50;

    logic            g_clk = 1'b0;
    logic            g_resetn;
    logic            flush;
    logic            in_valid;
    logic [XLEN-1:0] rs1, rs2, rs3;
    logic            op_maddlu, op_maddhu;
    logic            out_ready;

    logic            in_ready, out_valid;
    logic [XLEN-1:0] rd;
    logic            in_ready_51, out_valid_51;
    logic [XLEN-1:0] rd_51;

    int errors = 0;
    int checks = 0;

    always #5 g_clk = ~g_clk;

    x25519_ise_mac #(.XLEN(64), .LIMB_BITS(64), .MUL_W(16)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rs3(rs3),
        .op_maddlu(op_maddlu), .op_maddhu(op_maddhu),
        .out_valid(out_valid), .out_ready(out_ready), .rd(rd)
    );

    x25519_ise_mac #(.XLEN(64), .LIMB_BITS(51), .MUL_W(16)) dut51 (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_51),
        .rs1(rs1), .rs2(rs2), .rs3(rs3),
        .op_maddlu(op_maddlu), .op_maddhu(op_maddhu),
        .out_valid(out_valid_51), .out_ready(out_ready), .rd(rd_51)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] refModel(input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c, input logic lo,
                                             input logic hi, input int limb);
        logic [127:0] prod;
        logic [127:0] part;
        if (lo == hi) return 64'd0;
        prod = {64'd0, a} * {64'd0, b};
        if (lo) part = prod & ((128'd1 << limb) - 128'd1);
        else    part = prod >> limb;
        return part[63:0] + c;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Drive a request and return just after its acceptance edge; inputs are then scrambled.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                                 input logic lo, input logic hi);
        int w;
        w = 0;
        @(negedge g_clk);
        while (!in_ready && w < BOUND) begin
            @(negedge g_clk);
            w++;
        end
        if (w >= BOUND) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
        rs1 = a; rs2 = b; rs3 = c;
        op_maddlu = lo; op_maddhu = hi;
        in_valid = 1'b1;
        @(posedge g_clk);
        #1;
        in_valid = 1'b0;
        rs1 = rand64(); rs2 = rand64(); rs3 = rand64();
        op_maddlu = 1'($urandom); op_maddhu = 1'($urandom);
    endtask

    // Full transaction: latency, both results, stall behaviour and the handoff beat.
    task automatic runOp(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic lo, input logic hi,
                         input int stall);
        int lat;
        int exp_lat;
        applyStimulus(a, b, c, lo, hi);
        checkOutput({tag, ".busy"}, 64'(in_ready), 64'd0);
        exp_lat = (lo == hi) ? 0 : NIT + 1;
        lat = 0;
        while (!out_valid && lat < BOUND) begin
            @(posedge g_clk);
            #1;
            lat++;
        end
        checkOutput({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, ".rd"}, rd, refModel(a, b, c, lo, hi, 64));
        checkOutput({tag, ".rd51"}, rd_51, refModel(a, b, c, lo, hi, 51));
        checkOutput({tag, ".valid51"}, 64'(out_valid_51), 64'd1);
        if (stall > 0) begin
            repeat (stall) @(posedge g_clk);
            #1;
            checkOutput({tag, ".stall_valid"}, 64'(out_valid), 64'd1);
            checkOutput({tag, ".stall_rd"}, rd, refModel(a, b, c, lo, hi, 64));
            checkOutput({tag, ".stall_ready"}, 64'(in_ready), 64'd0);
        end
        @(negedge g_clk);
        out_ready = 1'b1;
        @(posedge g_clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, ".drop_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, ".idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] a, b, c;
        logic        lo, hi;
        logic        seen_valid;
        g_resetn = 1'b0; flush = 1'b0; in_valid = 1'b0;
        rs1 = '0; rs2 = '0; rs3 = '0;
        op_maddlu = 1'b0; op_maddhu = 1'b0; out_ready = 1'b0;
        #12;
        checkOutput("reset.in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset.rd", rd, 64'd0);
        @(negedge g_clk);
        g_resetn = 1'b1;

        runOp("lo_allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1, 1'b0, 0);
        checkOutput("lo_allones.const", refModel(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'd5, 1'b1, 1'b0, 64), 64'h6);
        runOp("hi_allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b0, 1'b1, 0);
        runOp("hi_2p51", 64'd1 << 51, 64'd1 << 51, 64'd1, 1'b0, 1'b1, 0);
        runOp("lo_2p51", 64'd1 << 51, 64'd1 << 51, 64'd1, 1'b1, 1'b0, 0);
        runOp("stall10", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'd77, 1'b0, 1'b1, 10);

        // Flush during the second MUL cycle: the result must never appear.
        applyStimulus(64'd1000, 64'd2000, 64'd3, 1'b1, 1'b0);
        @(posedge g_clk);
        @(negedge g_clk);
        flush = 1'b1;
        @(posedge g_clk);
        #1;
        flush = 1'b0;
        checkOutput("flush.in_ready", 64'(in_ready), 64'd1);
        seen_valid = out_valid;
        repeat (NIT + 3) begin
            @(posedge g_clk);
            #1;
            seen_valid = seen_valid | out_valid;
        end
        checkOutput("flush.no_valid", 64'(seen_valid), 64'd0);
        runOp("after_flush", 64'd3, 64'd7, 64'd1, 1'b1, 1'b0, 0);
        checkOutput("after_flush.const", refModel(64'd3, 64'd7, 64'd1, 1'b1, 1'b0, 64), 64'd22);

        // Flush together with a request in IDLE: nothing may be captured.
        @(negedge g_clk);
        flush = 1'b1; in_valid = 1'b1;
        rs1 = 64'd9; rs2 = 64'd9; rs3 = 64'd9; op_maddlu = 1'b1; op_maddhu = 1'b0;
        @(posedge g_clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        checkOutput("flush_win.in_ready", 64'(in_ready), 64'd1);
        seen_valid = out_valid;
        repeat (NIT + 3) begin
            @(posedge g_clk);
            #1;
            seen_valid = seen_valid | out_valid;
        end
        checkOutput("flush_win.no_valid", 64'(seen_valid), 64'd0);

        // Asynchronous reset mid-operation, after a nonzero result left rd populated.
        runOp("pre_reset", 64'd11, 64'd13, 64'd2, 1'b1, 1'b0, 0);
        applyStimulus(64'd5, 64'd6, 64'd7, 1'b1, 1'b0);
        @(posedge g_clk);
        #2;
        g_resetn = 1'b0;
        #1;
        checkOutput("async_reset.out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_reset.rd", rd, 64'd0);
        checkOutput("async_reset.in_ready", 64'(in_ready), 64'd1);
        @(negedge g_clk);
        g_resetn = 1'b1;

        runOp("illegal_both", 64'd5, 64'd6, 64'd7, 1'b1, 1'b1, 0);
        runOp("illegal_none", 64'd5, 64'd6, 64'd7, 1'b0, 1'b0, 2);

        // Randomised back-to-back traffic with random consumer stalls.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 64'hFFFF_FFFF_FFFF_FFFF;
                1:       a = 64'd1 << $urandom_range(0, 63);
                default: a = rand64();
            endcase
            b = ($urandom_range(0, 7) == 0) ? 64'd0 : rand64();
            c = rand64();
            case ($urandom_range(0, 9))
                0:       begin lo = 1'b1; hi = 1'b1; end
                1:       begin lo = 1'b0; hi = 1'b0; end
                2, 3, 4, 5: begin lo = 1'b1; hi = 1'b0; end
                default: begin lo = 1'b0; hi = 1'b1; end
            endcase
            runOp("random", a, b, c, lo, hi, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
